// File: rtl/axi_xbar_pkg.sv
// Shared crossbar definitions: sizes, RRESP codes, slave indices and the
// arbiter state type. Used by the R-channel arbiter and its round-robin picker.
package axi_xbar_pkg;

    // Crossbar geometry
    localparam int NUM_S  = 6;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;
    localparam int PTR_W  = $clog2(NUM_S);

    // RRESP encodings
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    // Slave port indices (address map order)
    localparam int S0 = 0;
    localparam int S1 = 1;
    localparam int S2 = 2;
    localparam int S3 = 3;
    localparam int S4 = 4;
    localparam int S5 = 5;

    // Arbiter state: IDLE arbitrates (one bubble), BURST forwards the owner
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Next slave index with an explicit wrap; NUM_S is not a power of two,
    // so natural counter overflow would visit unused indices.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(NUM_S - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector. Scans the request vector starting one
// past last_ptr, wrapping at NUM_S, and returns the first requester both as a
// one-hot vector and as an encoded index. Shared by the R, AW/W and B arbiters.
module rr_pick
    import axi_xbar_pkg::*;
(
    input  logic [NUM_S-1:0] req,
    input  logic [PTR_W-1:0] last_ptr,
    output logic [NUM_S-1:0] grant,
    output logic [PTR_W-1:0] idx,
    output logic             valid
);

    logic [PTR_W-1:0] start;
    logic [PTR_W-1:0] cand;

    assign start = next_ptr(last_ptr);

    // Walk NUM_S candidates from start; the first requesting one wins
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = start;
        for (int k = 0; k < NUM_S; k++) begin
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
            cand = next_ptr(cand);
        end
    end

endmodule

// File: rtl/axi_r_arbiter.sv
// R-channel return path: collects read beats from NUM_S slaves and returns
// them to one master port. Round-robin arbitration with the grant held until
// the RLAST beat handshakes, so bursts from different slaves never interleave.
//
// Handshake rules: a beat transfers on a rising edge where RVALID and RREADY
// are both high. M_RVALID never depends on M_RREADY; the granted slave's
// S_RREADY is a direct copy of M_RREADY, all other S_RREADY bits are 0.
module axi_r_arbiter
    import axi_xbar_pkg::*;
(
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [NUM_S-1:0]        S_RVALID,
    input  logic [NUM_S*DATA_W-1:0] S_RDATA,
    input  logic [NUM_S*ID_W-1:0]   S_RID,
    input  logic [NUM_S*2-1:0]      S_RRESP,
    input  logic [NUM_S-1:0]        S_RLAST,
    output logic [NUM_S-1:0]        S_RREADY,
    output logic                    M_RVALID,
    output logic [DATA_W-1:0]       M_RDATA,
    output logic [ID_W-1:0]         M_RID,
    output logic [1:0]              M_RRESP,
    output logic                    M_RLAST,
    input  logic                    M_RREADY,
    output logic [NUM_S-1:0]        GRANT
);

    arb_state_t       state;
    logic [NUM_S-1:0] grant_q;
    logic [PTR_W-1:0] gidx;
    logic [PTR_W-1:0] last_ptr;

    logic [NUM_S-1:0] pick_grant;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_valid;
    logic             active;
    logic             last_hs;

    rr_pick u_rr_pick (
        .req      (S_RVALID),
        .last_ptr (last_ptr),
        .grant    (pick_grant),
        .idx      (pick_idx),
        .valid    (pick_valid)
    );

    // Forwarding is live only while a burst owner exists and reset is low
    assign active  = (state == BURST) && !ARESET;

    // Final beat of the owner's burst completes on this edge
    assign last_hs = S_RVALID[gidx] && M_RREADY && S_RLAST[gidx];

    // Arbitration FSM: IDLE registers a winner, BURST holds it until RLAST
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state    <= IDLE;
            grant_q  <= '0;
            gidx     <= '0;
            last_ptr <= PTR_W'(NUM_S - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state    <= BURST;
                        grant_q  <= pick_grant;
                        gidx     <= pick_idx;
                        last_ptr <= pick_idx;
                    end
                end
                BURST: begin
                    if (last_hs) begin
                        state   <= IDLE;
                        grant_q <= '0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    // Zero-latency mux from the owner to the master; all zero otherwise
    always_comb begin
        M_RVALID = 1'b0;
        M_RDATA  = '0;
        M_RID    = '0;
        M_RRESP  = '0;
        M_RLAST  = 1'b0;
        S_RREADY = '0;
        if (active) begin
            M_RVALID = S_RVALID[gidx];
            M_RDATA  = S_RDATA[int'(gidx)*DATA_W +: DATA_W];
            M_RID    = S_RID[int'(gidx)*ID_W +: ID_W];
            M_RRESP  = S_RRESP[int'(gidx)*2 +: 2];
            M_RLAST  = S_RLAST[gidx];
            S_RREADY = grant_q & {NUM_S{M_RREADY}};
        end
    end

    assign GRANT = ARESET ? '0 : grant_q;

endmodule

// File: tb/tb_axi_r_arbiter.sv
// Bench for axi_r_arbiter: a per-cycle vector table for the arbitration FSM,
// directed burst sequences, and randomized bursts checked against a
// burst-level round-robin model.
module tb_axi_r_arbiter;
    import axi_xbar_pkg::*;

    localparam int BW = DATA_W + ID_W + 2 + 1;  // {data, id, resp, last}

    logic                    ACLK;
    logic                    ARESET;
    logic [NUM_S-1:0]        S_RVALID;
    logic [NUM_S*DATA_W-1:0] S_RDATA;
    logic [NUM_S*ID_W-1:0]   S_RID;
    logic [NUM_S*2-1:0]      S_RRESP;
    logic [NUM_S-1:0]        S_RLAST;
    logic [NUM_S-1:0]        S_RREADY;
    logic                    M_RVALID;
    logic [DATA_W-1:0]       M_RDATA;
    logic [ID_W-1:0]         M_RID;
    logic [1:0]              M_RRESP;
    logic                    M_RLAST;
    logic                    M_RREADY;
    logic [NUM_S-1:0]        GRANT;

    axi_r_arbiter dut (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .S_RVALID (S_RVALID),
        .S_RDATA  (S_RDATA),
        .S_RID    (S_RID),
        .S_RRESP  (S_RRESP),
        .S_RLAST  (S_RLAST),
        .S_RREADY (S_RREADY),
        .M_RVALID (M_RVALID),
        .M_RDATA  (M_RDATA),
        .M_RID    (M_RID),
        .M_RRESP  (M_RRESP),
        .M_RLAST  (M_RLAST),
        .M_RREADY (M_RREADY),
        .GRANT    (GRANT)
    );

    // Clock / reset
    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int checks   = 0;
    int failures = 0;
    int hs_cnt   = 0;
    int model_ptr = NUM_S - 1;

    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] sq[NUM_S][$];
    logic [NUM_S-1:0] in_burst = '0;

    typedef struct {
        logic             arst;
        logic [NUM_S-1:0] rvalid;
        logic [NUM_S-1:0] rlast;
        logic             rready;
        logic             e_mvalid;
        logic [31:0]      e_mdata;
        logic             e_mlast;
        logic [NUM_S-1:0] e_sready;
        logic [NUM_S-1:0] e_grant;
    } vec_t;
    vec_t vt[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Queue one burst of n beats on a slave; data counts up from base
    task automatic push_burst(input int s, input int n, input logic [3:0] id,
                              input logic [1:0] resp, input logic [31:0] base);
        for (int b = 0; b < n; b++) begin
            sq[s].push_back({base + 32'(b), id, resp, (b == n - 1)});
        end
    endtask

    // Burst-level model: every pending slave presents its head at each
    // arbitration, so whole bursts leave in round-robin order after model_ptr.
    task automatic plan();
        logic [BW-1:0] tmp[NUM_S][$];
        logic [BW-1:0] b;
        int found;
        for (int i = 0; i < NUM_S; i++) tmp[i] = sq[i];
        forever begin
            found = -1;
            for (int k = 1; k <= NUM_S; k++) begin
                if (found < 0 && tmp[(model_ptr + k) % NUM_S].size() > 0)
                    found = (model_ptr + k) % NUM_S;
            end
            if (found < 0) break;
            do begin
                b = tmp[found].pop_front();
                exp_q.push_back(b);
            end while (!b[0]);
            model_ptr = found;
        end
    endtask

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < NUM_S; i++) n += sq[i].size();
        return n;
    endfunction

    // Driver + monitor for one cycle. rdy: 0/1 fixed, 2 random.
    task automatic step(input int rdy, input bit gaps, input bit rst);
        logic [BW-1:0] b;
        logic gap;
        @(negedge ACLK);
        ARESET = rst;
        for (int i = 0; i < NUM_S; i++) begin
            gap = gaps && in_burst[i] && ($urandom_range(0, 3) == 0);
            if (sq[i].size() > 0 && !gap) begin
                b = sq[i][0];
                S_RVALID[i] = 1'b1;
                S_RDATA[i*DATA_W +: DATA_W] = b[BW-1 -: DATA_W];
                S_RID[i*ID_W +: ID_W] = b[6:3];
                S_RRESP[i*2 +: 2] = b[2:1];
                S_RLAST[i] = b[0];
            end else begin
                S_RVALID[i] = 1'b0;
                S_RDATA[i*DATA_W +: DATA_W] = '0;
                S_RID[i*ID_W +: ID_W] = '0;
                S_RRESP[i*2 +: 2] = '0;
                S_RLAST[i] = 1'b0;
            end
        end
        M_RREADY = (rdy == 2) ? 1'($urandom_range(0, 1)) : 1'(rdy);
        #1;
        check("sready_outside_grant", 64'(S_RREADY & ~GRANT), 64'd0);
        if (rst) begin
            check("reset_mvalid", 64'(M_RVALID), 64'd0);
            check("reset_grant", 64'(GRANT), 64'd0);
        end
        if (M_RVALID && M_RREADY) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL extra_beat actual=%0h required=none", {M_RDATA, M_RID, M_RRESP, M_RLAST});
            end else begin
                check("beat", 64'({M_RDATA, M_RID, M_RRESP, M_RLAST}), 64'(exp_q.pop_front()));
            end
        end
        for (int i = 0; i < NUM_S; i++) begin
            if (S_RVALID[i] && S_RREADY[i]) begin
                b = sq[i].pop_front();
                in_burst[i] = !b[0];
            end
        end
    endtask

    task automatic clear_all();
        exp_q.delete();
        for (int i = 0; i < NUM_S; i++) sq[i].delete();
        in_burst = '0;
    endtask

    task automatic do_reset(input int n);
        repeat (n) step(1, 1'b0, 1'b1);
        model_ptr = NUM_S - 1;
        in_burst  = '0;
    endtask

    // Run until all queued beats have reached the master, bounded
    task automatic run_all(input int budget, input int rdy, input bit gaps);
        int n = 0;
        while ((exp_q.size() > 0 || pending() > 0) && n < budget) begin
            step(rdy, gaps, 1'b0);
            n++;
        end
        check("drain_left", 64'(exp_q.size() + pending()), 64'd0);
        if (exp_q.size() + pending() > 0) clear_all();
    endtask

    initial begin
        logic [31:0] pat_d[5];
        int          pat_r[5];
        int          h0;

        ARESET   = 1'b1;
        S_RVALID = '0;
        S_RLAST  = '0;
        M_RREADY = 1'b0;
        for (int i = 0; i < NUM_S; i++) begin
            S_RDATA[i*DATA_W +: DATA_W] = 32'hD000_0000 + 32'(i);
            S_RID[i*ID_W +: ID_W] = 4'(i);
            S_RRESP[i*2 +: 2] = 2'(i);
        end

        // ---- vector table: {arst, rvalid, rlast, rready | mvalid, mdata, mlast, sready, grant}
        vt[0]  = '{1'b1, 6'b111111, 6'b000000, 1'b1, 1'b0, 32'h0,         1'b0, 6'b000000, 6'b000000};
        vt[1]  = '{1'b1, 6'b111111, 6'b000000, 1'b1, 1'b0, 32'h0,         1'b0, 6'b000000, 6'b000000};
        vt[2]  = '{1'b1, 6'b111111, 6'b000000, 1'b1, 1'b0, 32'h0,         1'b0, 6'b000000, 6'b000000};
        vt[3]  = '{1'b0, 6'b000000, 6'b000000, 1'b1, 1'b0, 32'h0,         1'b0, 6'b000000, 6'b000000};
        vt[4]  = '{1'b0, 6'b001000, 6'b000000, 1'b1, 1'b0, 32'h0,         1'b0, 6'b000000, 6'b000000};
        vt[5]  = '{1'b0, 6'b001001, 6'b000000, 1'b1, 1'b1, 32'hD000_0003, 1'b0, 6'b001000, 6'b001000};
        vt[6]  = '{1'b0, 6'b001001, 6'b001000, 1'b0, 1'b1, 32'hD000_0003, 1'b1, 6'b000000, 6'b001000};
        vt[7]  = '{1'b0, 6'b001001, 6'b001000, 1'b1, 1'b1, 32'hD000_0003, 1'b1, 6'b001000, 6'b001000};
        vt[8]  = '{1'b0, 6'b001001, 6'b000000, 1'b1, 1'b0, 32'h0,         1'b0, 6'b000000, 6'b000000};
        vt[9]  = '{1'b0, 6'b001001, 6'b000001, 1'b1, 1'b1, 32'hD000_0000, 1'b1, 6'b000001, 6'b000001};
        vt[10] = '{1'b0, 6'b001000, 6'b000000, 1'b1, 1'b0, 32'h0,         1'b0, 6'b000000, 6'b000000};
        vt[11] = '{1'b0, 6'b000000, 6'b000000, 1'b1, 1'b0, 32'hD000_0003, 1'b0, 6'b001000, 6'b001000};
        vt[12] = '{1'b0, 6'b100000, 6'b100000, 1'b1, 1'b0, 32'hD000_0003, 1'b0, 6'b001000, 6'b001000};
        vt[13] = '{1'b1, 6'b100001, 6'b000000, 1'b1, 1'b0, 32'h0,         1'b0, 6'b000000, 6'b000000};
        vt[14] = '{1'b0, 6'b100001, 6'b000000, 1'b1, 1'b0, 32'h0,         1'b0, 6'b000000, 6'b000000};
        vt[15] = '{1'b0, 6'b100001, 6'b000001, 1'b1, 1'b1, 32'hD000_0000, 1'b1, 6'b000001, 6'b000001};

        for (int r = 0; r < 16; r++) begin
            @(negedge ACLK);
            ARESET   = vt[r].arst;
            S_RVALID = vt[r].rvalid;
            S_RLAST  = vt[r].rlast;
            M_RREADY = vt[r].rready;
            #1;
            check($sformatf("vec%0d_mvalid", r), 64'(M_RVALID), 64'(vt[r].e_mvalid));
            check($sformatf("vec%0d_mdata", r),  64'(M_RDATA),  64'(vt[r].e_mdata));
            check($sformatf("vec%0d_mlast", r),  64'(M_RLAST),  64'(vt[r].e_mlast));
            check($sformatf("vec%0d_sready", r), 64'(S_RREADY), 64'(vt[r].e_sready));
            check($sformatf("vec%0d_grant", r),  64'(GRANT),    64'(vt[r].e_grant));
        end

        // ---- S2 alone, 4 beats: one bubble, then 4 consecutive beats
        do_reset(2);
        push_burst(S2, 4, 4'h3, OKAY, 32'hA0);
        plan();
        step(1, 1'b0, 1'b0);
        check("s2_bubble_grant", 64'(GRANT), 64'd0);
        check("s2_bubble_mvalid", 64'(M_RVALID), 64'd0);
        for (int b = 0; b < 4; b++) begin
            step(1, 1'b0, 1'b0);
            check($sformatf("s2_beat%0d_grant", b), 64'(GRANT), 64'b000100);
            check($sformatf("s2_beat%0d_mvalid", b), 64'(M_RVALID), 64'd1);
            check($sformatf("s2_beat%0d_mlast", b), 64'(M_RLAST), 64'(b == 3));
        end
        step(1, 1'b0, 1'b0);
        check("s2_idle_grant", 64'(GRANT), 64'd0);
        check("s2_left", 64'(exp_q.size()), 64'd0);

        // ---- S1 burst of 3 under ready pattern 1,0,0,1,1
        push_burst(S1, 3, 4'h5, EXOKAY, 32'hB0);
        plan();
        step(1, 1'b0, 1'b0);
        pat_r = '{1, 0, 0, 1, 1};
        pat_d = '{32'hB0, 32'hB1, 32'hB1, 32'hB1, 32'hB2};
        h0 = hs_cnt;
        for (int c = 0; c < 5; c++) begin
            step(pat_r[c], 1'b0, 1'b0);
            check($sformatf("s1_c%0d_mdata", c), 64'(M_RDATA), 64'(pat_d[c]));
            check($sformatf("s1_c%0d_sready", c), 64'(S_RREADY), 64'(pat_r[c] << S1));
        end
        check("s1_beats", 64'(hs_cnt - h0), 64'd3);

        // ---- S0, S3, S5 together after reset, then S0 + S3 again
        do_reset(1);
        push_burst(S0, 1, 4'h0, OKAY, 32'hC0);
        push_burst(S3, 1, 4'h3, OKAY, 32'hC3);
        push_burst(S5, 1, 4'h5, OKAY, 32'hC5);
        plan();
        run_all(50, 1, 1'b0);
        push_burst(S0, 1, 4'h0, OKAY, 32'hE0);
        push_burst(S3, 1, 4'h3, OKAY, 32'hE3);
        plan();
        run_all(50, 1, 1'b0);

        // ---- Reset in the middle of an S4 burst while S0 waits
        push_burst(S4, 4, 4'h4, OKAY, 32'hF0);
        plan();
        h0 = hs_cnt;
        for (int c = 0; c < 20 && hs_cnt - h0 < 2; c++) step(1, 1'b0, 1'b0);
        check("s4_two_beats", 64'(hs_cnt - h0), 64'd2);
        push_burst(S0, 1, 4'h0, OKAY, 32'h50);
        step(1, 1'b0, 1'b1);
        exp_q.delete();
        sq[S4].delete();
        in_burst  = '0;
        model_ptr = NUM_S - 1;
        plan();
        step(1, 1'b0, 1'b0);
        check("post_rst_grant", 64'(GRANT), 64'd0);
        check("post_rst_mvalid", 64'(M_RVALID), 64'd0);
        check("post_rst_mdata", 64'(M_RDATA), 64'd0);
        check("post_rst_sready", 64'(S_RREADY), 64'd0);
        step(1, 1'b0, 1'b0);
        check("post_rst_s0_first", 64'(GRANT), 64'b000001);
        run_all(50, 1, 1'b0);

        // ---- S5 DECERR burst, RID and RRESP passed through
        push_burst(S5, 2, 4'h1, DECERR, 32'h11);
        plan();
        h0 = hs_cnt;
        for (int c = 0; c < 20 && hs_cnt - h0 < 2; c++) begin
            step(1, 1'b0, 1'b0);
            if (M_RVALID) begin
                check("decerr_rresp", 64'(M_RRESP), 64'(DECERR));
                check("decerr_rid", 64'(M_RID), 64'h1);
            end
        end
        check("decerr_beats", 64'(hs_cnt - h0), 64'd2);

        // ---- Fairness: every slave holds two bursts
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NUM_S; i++)
                push_burst(i, $urandom_range(1, 3), 4'(i), 2'($urandom_range(0, 3)), 32'($urandom));
        plan();
        run_all(500, 2, 1'b0);

        // ---- Random bursts, random back-pressure and mid-burst RVALID gaps
        for (int round = 0; round < 30; round++) begin
            for (int i = 0; i < NUM_S; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    repeat ($urandom_range(1, 2))
                        push_burst(i, $urandom_range(1, 8), 4'($urandom), 2'($urandom), 32'($urandom));
                end
            end
            plan();
            run_all(2000, 2, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_r_arbiter.md
Name: axi_r_arbiter

Overview:
- Read-data (R channel) return path of the crossbar.
- The address decoder steers AR requests toward slaves S0–S5. This block carries the opposite direction: it collects R beats from those six slaves and returns them to the single master port.
- Arbitration is round-robin. A grant is held until the beat carrying RLAST completes its handshake, so bursts are never interleaved.
- One instance per master port.

Parameters:
- NUM_S, 6, number of slave ports (S0–S5 address map).
- DATA_W, 32, RDATA width.
- ID_W, 4, RID width.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  reset, synchronous, active-high.
- S_RVALID  in  NUM_S  per-slave RVALID.
- S_RDATA  in  NUM_S*DATA_W  per-slave RDATA; slave i occupies bits [i*DATA_W +: DATA_W].
- S_RID  in  NUM_S*ID_W  per-slave RID, same packing.
- S_RRESP  in  NUM_S*2  per-slave RRESP, same packing.
- S_RLAST  in  NUM_S  per-slave RLAST.
- S_RREADY  out  NUM_S  per-slave RREADY.
- M_RVALID  out  1  to master.
- M_RDATA  out  DATA_W  to master.
- M_RID  out  ID_W  to master.
- M_RRESP  out  2  to master.
- M_RLAST  out  1  to master.
- M_RREADY  in  1  from master.
- GRANT  out  NUM_S  one-hot current owner; 0 when idle (debug/perf).

Behaviour:
- Reset values:
  - state=IDLE, GRANT=0, last_ptr=NUM_S-1, so S0 has top priority after reset.
  - While in reset or IDLE: M_RVALID=0, M_RDATA=0, M_RID=0, M_RRESP=0, M_RLAST=0, S_RREADY=0.
- State IDLE:
  - If any S_RVALID bit is set, pick the first set bit scanning from last_ptr+1 upward, wrapping modulo NUM_S.
  - Register the winner into GRANT and last_ptr, then go to BURST.
  - Nothing is forwarded in this cycle. Arbitration costs exactly one bubble cycle per burst.
- State BURST, with g the granted index:
  - M_RVALID=S_RVALID[g]; M_RDATA, M_RID, M_RRESP, M_RLAST are muxed from slave g.
  - S_RREADY[g]=M_RREADY; all other S_RREADY bits are 0.
  - The mux is purely combinational, so there is zero-cycle latency through BURST.
- BURST exit:
  - On a handshake (S_RVALID[g] & M_RREADY) with S_RLAST[g]=1, go to IDLE and clear GRANT in the same edge.
  - A handshake with RLAST=0 stays in BURST.
- Non-granted slaves:
  - Never see RREADY and must hold their beat (AXI rules).
  - No beat from a non-granted slave reaches the master.
- Mid-burst RVALID drop by the granted slave:
  - M_RVALID follows it low and the grant is held.
  - No re-arbitration until RLAST completes.
- Back-pressure: with M_RREADY=0, outputs mirror the held slave beat, the state is unchanged, and S_RREADY[g]=0.
- Simultaneous requests: resolved by the round-robin pointer only; RID and RRESP have no influence.
- Fairness: with all NUM_S slaves continuously requesting, each is granted once per NUM_S bursts.
- RLAST handshake in the same cycle as new requests from other slaves: return to IDLE; the new arbitration happens the following cycle (bubble preserved).
- Reset mid-burst:
  - On the next edge, state=IDLE, GRANT=0, last_ptr=NUM_S-1, outputs 0.
  - The partial burst is dropped; upstream slaves are also reset.
- Widths:
  - last_ptr is $clog2(NUM_S) bits.
  - Wrap uses an explicit compare to NUM_S-1, not power-of-two overflow, because NUM_S=6.
- No combinational path from M_RREADY to any RVALID output; S_RREADY depends on M_RREADY only (AXI-legal).

Decomposition:
- Shared package axi_xbar_pkg holds:
  - NUM_S, DATA_W, ID_W;
  - RRESP encodings OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - slave index constants S0..S5;
  - the arbiter state enum {IDLE, BURST}.
- One sub-module: rr_pick.
  - Combinational round-robin selector.
  - Inputs: req[NUM_S], last_ptr.
  - Outputs: one-hot grant, encoded index.
  - Reused later by the AW/W and B-channel arbiters.

Test Plan:
- Reset with S_RVALID=6'b111111 and ARESET=1 for 3 cycles -> M_RVALID=0, S_RREADY=0, GRANT=0 throughout.
- S2 alone sends a 4-beat burst (RDATA 0xA0..0xA3, RID=3, RRESP=OKAY), M_RREADY=1 -> GRANT=6'b000100 one cycle after RVALID; master sees 4 beats in 4 consecutive cycles, RLAST on 0xA3; IDLE the next cycle.
- S0, S3, S5 each request a 1-beat burst in the same cycle after reset -> grant order S0, S3, S5; then S0 re-requests with S3 again -> S3 is not granted before S0 (pointer at S5 wraps to S0).
- S1 burst of 3 with M_RREADY toggling 1,0,0,1,1 -> beats accepted only on ready cycles; M_RDATA stable while stalled; S1's S_RREADY mirrors M_RREADY.
- S4 mid-burst (beat 2 of 4), ARESET pulsed for 1 cycle while S0 is requesting -> next cycle GRANT=0 and outputs 0; after release S0 is granted first (last_ptr reset to 5).
- S5 returns a 2-beat burst with RRESP=DECERR (0x11) -> M_RRESP=2'b11 on both beats, passed unmodified; RID preserved.
